draw_port_arbiter: RTL and testbench
====================================

# draw_port_arbiter

Shares the single VGA pixel-write port (x, y, colour, plot) between several independent draw engines: background, car sprite, start/win screens and HUD timer digits. Each engine requests the port, owns it for a whole burst, and releases it. Grants rotate round-robin. Ownership has a time limit, and frame overruns are flagged. The block sits between the draw engines and the registered VGA output stage in the top level.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- MAX_BURST, 100_000, maximum cycles one owner may hold the port; must exceed 320×240 = 76_800
- CNT_W, $clog2(MAX_BURST+1), width of the burst counter

Ports:
- Clock  in  1  system clock, 50 MHz
- Resetn  in  1  synchronous, active-low reset
- frameTick  in  1  one-cycle pulse per frame (Enable1Frame)
- clearFlags  in  1  clears the sticky flags
- req  in  NREQ  per-requester port request, level
- done  in  NREQ  per-requester end-of-burst pulse
- xIn  in  9·NREQ  flattened x coordinates; requester i uses bits [9i+8:9i]
- yIn  in  8·NREQ  flattened y coordinates
- colourIn  in  6·NREQ  flattened colours
- plotIn  in  NREQ  per-requester pixel-write strobe
- grant  out  NREQ  one-hot grant, registered
- xOut  out  9  registered pixel x
- yOut  out  8  registered pixel y
- colourOut  out  6  registered pixel colour
- plotOut  out  1  registered pixel-write strobe
- busy  out  1  high while the port is owned
- frameOverrun  out  1  sticky flag
- timeoutFlag  out  1  sticky flag

## Operation
- States: IDLE and OWN.
- IDLE, some req bit high:
  - pick the winner round-robin, searching from lastGrant+1 upward with wrap modulo NREQ;
  - grant[w] <= 1, owner <= w, burstCnt <= 0, go to OWN.
- IDLE, no req: stay in IDLE with grant = 0.
- OWN:
  - Each cycle, the owner's x, y, colour and plot are registered onto the outputs. Writes from non-owners are ignored.
  - burstCnt increments every cycle.
- Release from OWN, in priority order; every release sets grant <= 0, lastGrant <= owner, and returns to IDLE:
  - done[owner] = 1, or req[owner] = 0;
  - burstCnt == MAX_BURST-1: forced release, and timeoutFlag <= 1.
- A done pulse from a non-owner is ignored.
- The release cycle's pixel is still forwarded if plotIn[owner] = 1.
- At least one IDLE cycle separates consecutive grants, so a grant is never handed straight from one owner to the next.
- frameOverrun <= 1 when frameTick = 1 while in OWN.
- Flag clearing:
  - clearFlags = 1 clears both sticky flags;
  - if a set condition occurs in the same cycle, set wins.
- busy is high exactly when state = OWN.

## Timing
- Reset values:
  - state IDLE; grant 0, busy 0;
  - xOut 0, yOut 0, colourOut 0, plotOut 0;
  - frameOverrun 0, timeoutFlag 0;
  - lastGrant = NREQ-1, so req[0] has first priority after reset.
- Grant latency: req rises in cycle t; grant is high in t+1 and busy is high in t+1.
- Pixel latency: owner drives plotIn/x/y/colour in cycle c; the values appear on the outputs in c+1.
- Release: done[owner] in cycle r; grant is low in r+1. The earliest next grant is r+2.
- Reset mid-burst: on the next edge all outputs return to reset values, plotOut drops immediately, and lastGrant is reinitialised.
- Outputs are driven only from registers; there is no combinational path from inputs to outputs.

## Structure
- Shared package draw_pkg, holding:
  - X_W = 9, Y_W = 8, C_W = 6;
  - the state enum {IDLE, OWN};
  - default NREQ and MAX_BURST.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req and lastGrant.
  - Outputs: winner index and a valid bit.
- Output mux and flags live in the top-level arbiter body.

## Test plan
- **Reset and first grant:** hold Resetn = 0 for 2 cycles, then set req = 4'b1111 → grant = 4'b0001 one cycle later. Outputs are all zero during reset.
- **Round-robin:** keep req = 4'b1111 and pulse done from each owner 3 cycles into its grant → grant sequence 0001, 0010, 0100, 1000, 0001, with exactly one idle cycle between grants.
- **Pixel forwarding:** owner 2 drives x = 9'd319, y = 8'd239, colour = 6'h3F, plot = 1 while owner 0 drives plot = 1 with other values → next cycle xOut = 319, yOut = 239, colourOut = 3F, plotOut = 1. Owner 0's values never appear.
- **Timeout:** MAX_BURST = 16; owner never pulses done → grant drops after 16 cycles and timeoutFlag = 1. clearFlags then clears it.
- **Overrun and flag precedence:** frameTick during OWN → frameOverrun = 1. frameTick together with clearFlags in the same cycle → frameOverrun remains 1.
- **Reset mid-burst:** Resetn = 0 while owner 1 is plotting → next cycle grant = 0, plotOut = 0. After release of reset with req = 4'b0011, the grant goes to requester 0.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared definitions for the VGA draw-port arbitration slice:
// pixel field widths, arbiter state encoding and default sizing.
package draw_pkg;

   localparam int X_W           = 9;
   localparam int Y_W           = 8;
   localparam int C_W           = 6;
   localparam int DEF_NREQ      = 4;
   localparam int DEF_MAX_BURST = 100_000;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester found searching upward
// from the previous owner + 1, wrapping modulo NREQ.
module rr_pick
   import draw_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  i_req,
   input  logic [IDX_W-1:0] i_last_grant,
   output logic [IDX_W-1:0] o_winner,
   output logic             o_valid
);

   // NOTE: every output gets a default before the search so no latch is inferred.
   always_comb begin
      o_winner = '0;
      o_valid  = 1'b0;
      // Walk from the farthest candidate back to the nearest; the last hit wins.
      for (int k = NREQ; k >= 1; k--) begin
         if (i_req[(int'(i_last_grant) + k) % NREQ]) begin
            o_winner = IDX_W'((int'(i_last_grant) + k) % NREQ);
            o_valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/draw_port_arbiter.sv
// Round-robin owner of the shared VGA pixel-write port, with burst time limit,
// registered pixel forwarding and sticky overrun/timeout flags.
module draw_port_arbiter
   import draw_pkg::*;
#(
   parameter int NREQ      = DEF_NREQ,
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic                Clock,
   input  logic                Resetn,
   input  logic                frameTick,
   input  logic                clearFlags,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ-1:0]     done,
   input  logic [X_W*NREQ-1:0] xIn,
   input  logic [Y_W*NREQ-1:0] yIn,
   input  logic [C_W*NREQ-1:0] colourIn,
   input  logic [NREQ-1:0]     plotIn,
   output logic [NREQ-1:0]     grant,
   output logic [X_W-1:0]      xOut,
   output logic [Y_W-1:0]      yOut,
   output logic [C_W-1:0]      colourOut,
   output logic                plotOut,
   output logic                busy,
   output logic                frameOverrun,
   output logic                timeoutFlag
);

   localparam int IDX_W = $clog2(NREQ);

   state_t           r_state, w_state_nxt;
   logic [NREQ-1:0]  r_grant;
   logic [IDX_W-1:0] r_owner, r_last_grant;
   logic [CNT_W-1:0] r_burst_cnt;
   logic [X_W-1:0]   r_x;
   logic [Y_W-1:0]   r_y;
   logic [C_W-1:0]   r_colour;
   logic             r_plot, r_frame_overrun, r_timeout;

   logic [IDX_W-1:0] w_pick;
   logic             w_pick_valid, w_release, w_timeout;

   rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr_pick (
      .i_req        (req),
      .i_last_grant (r_last_grant),
      .o_winner     (w_pick),
      .o_valid      (w_pick_valid)
   );

   // Owner-requested release outranks the forced timeout release.
   always_comb begin
      w_state_nxt = r_state;
      w_release   = 1'b0;
      w_timeout   = 1'b0;
      if (r_state == IDLE) begin
         if (w_pick_valid) w_state_nxt = OWN;
      end else begin
         if (done[r_owner] || !req[r_owner]) begin
            w_release   = 1'b1;
            w_state_nxt = IDLE;
         end else if (r_burst_cnt == CNT_W'(MAX_BURST - 1)) begin
            w_release   = 1'b1;
            w_timeout   = 1'b1;
            w_state_nxt = IDLE;
         end
      end
   end

   // NOTE: synchronous reset inside the clocked block; all state uses non-blocking <=.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         r_state         <= IDLE;
         r_grant         <= '0;
         r_owner         <= '0;
         r_last_grant    <= IDX_W'(NREQ - 1);
         r_burst_cnt     <= '0;
         r_x             <= '0;
         r_y             <= '0;
         r_colour        <= '0;
         r_plot          <= 1'b0;
         r_frame_overrun <= 1'b0;
         r_timeout       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE) begin
            r_plot <= 1'b0;
            if (w_pick_valid) begin
               r_grant     <= NREQ'(1) << w_pick;
               r_owner     <= w_pick;
               r_burst_cnt <= '0;
            end
         end else begin
            // Release cycle still forwards the owner's pixel.
            r_x         <= xIn[X_W*r_owner +: X_W];
            r_y         <= yIn[Y_W*r_owner +: Y_W];
            r_colour    <= colourIn[C_W*r_owner +: C_W];
            r_plot      <= plotIn[r_owner];
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            if (w_release) begin
               r_grant      <= '0;
               r_last_grant <= r_owner;
            end
         end

         if (frameTick && r_state == OWN) r_frame_overrun <= 1'b1;
         else if (clearFlags)              r_frame_overrun <= 1'b0;

         if (w_timeout)       r_timeout <= 1'b1;
         else if (clearFlags) r_timeout <= 1'b0;
      end
   end

   assign grant        = r_grant;
   assign xOut         = r_x;
   assign yOut         = r_y;
   assign colourOut    = r_colour;
   assign plotOut      = r_plot;
   assign busy         = (r_state == OWN);
   assign frameOverrun = r_frame_overrun;
   assign timeoutFlag  = r_timeout;

endmodule

// File: tb/tb_draw_port_arbiter.sv
// Self-checking bench for draw_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_draw_port_arbiter;

   localparam int NREQ      = 4;
   localparam int MAX_BURST = 16;

   logic              Clock = 1'b0;
   logic              Resetn;
   logic              frameTick, clearFlags;
   logic [NREQ-1:0]   req, done, plotIn;
   logic [9*NREQ-1:0] xIn;
   logic [8*NREQ-1:0] yIn;
   logic [6*NREQ-1:0] colourIn;
   logic [NREQ-1:0]   grant;
   logic [8:0]        xOut;
   logic [7:0]        yOut;
   logic [5:0]        colourOut;
   logic              plotOut, busy, frameOverrun, timeoutFlag;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;
   int n_own;

   draw_port_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
      .Clock        (Clock),
      .Resetn       (Resetn),
      .frameTick    (frameTick),
      .clearFlags   (clearFlags),
      .req          (req),
      .done         (done),
      .xIn          (xIn),
      .yIn          (yIn),
      .colourIn     (colourIn),
      .plotIn       (plotIn),
      .grant        (grant),
      .xOut         (xOut),
      .yOut         (yOut),
      .colourOut    (colourOut),
      .plotOut      (plotOut),
      .busy         (busy),
      .frameOverrun (frameOverrun),
      .timeoutFlag  (timeoutFlag)
   );

   always #10 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: who owns the port, for how many cycles, and what it last forwarded.
   typedef struct {
      bit         busy;
      int         owner;
      int         last;
      int         len;
      logic [3:0] grant;
      logic [8:0] x;
      logic [7:0] y;
      logic [5:0] c;
      logic       plot;
      logic       ovr;
      logic       tmo;
   } model_t;

   model_t m;

   function automatic model_t model_next(model_t cur);
      model_t n        = cur;
      bit     was_busy = cur.busy;
      bit     forced   = 1'b0;
      if (!Resetn) begin
         n      = '{default: 0};
         n.last = NREQ - 1;
         return n;
      end
      if (cur.busy) begin
         n.x    = xIn[9*cur.owner +: 9];
         n.y    = yIn[8*cur.owner +: 8];
         n.c    = colourIn[6*cur.owner +: 6];
         n.plot = plotIn[cur.owner];
         n.len  = cur.len + 1;
         if (done[cur.owner] || !req[cur.owner] || n.len == MAX_BURST) begin
            forced = !(done[cur.owner] || !req[cur.owner]);
            n.busy  = 1'b0;
            n.grant = '0;
            n.last  = cur.owner;
         end
      end else begin
         n.plot = 1'b0;
         for (int k = 1; k <= NREQ; k++) begin
            int cand = (cur.last + k) % NREQ;
            if (!n.busy && req[cand]) begin
               n.busy  = 1'b1;
               n.owner = cand;
               n.len   = 0;
               n.grant = 4'(1 << cand);
            end
         end
      end
      if (frameTick && was_busy) n.ovr = 1'b1;
      else if (clearFlags)       n.ovr = 1'b0;
      if (forced)          n.tmo = 1'b1;
      else if (clearFlags) n.tmo = 1'b0;
      return n;
   endfunction

   always @(posedge Clock) m <= model_next(m);

   always @(negedge Clock) begin
      if (chk_on) begin
         check("m_grant",  32'(grant),        32'(m.grant));
         check("m_busy",   32'(busy),         32'(m.busy));
         check("m_plot",   32'(plotOut),      32'(m.plot));
         check("m_x",      32'(xOut),         32'(m.x));
         check("m_y",      32'(yOut),         32'(m.y));
         check("m_colour", 32'(colourOut),    32'(m.c));
         check("m_ovr",    32'(frameOverrun), 32'(m.ovr));
         check("m_tmo",    32'(timeoutFlag),  32'(m.tmo));
      end
   end

   task automatic step();
      @(posedge Clock);
      #2;
   endtask

   initial begin
      Resetn = 1'b0; frameTick = 1'b0; clearFlags = 1'b0;
      req = '0; done = '0; plotIn = '0; xIn = '0; yIn = '0; colourIn = '0;

      // Reset and first grant
      step();
      chk_on = 1'b1;
      step();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_pix",   32'({xOut, yOut, colourOut, plotOut}), 32'd0);
      check("rst_flags", 32'({frameOverrun, timeoutFlag}), 32'd0);
      Resetn = 1'b1;
      req    = 4'b1111;
      step();
      check("first_grant", 32'(grant), 32'b0001);
      check("first_busy",  32'(busy), 32'd1);

      // Round-robin with one idle cycle between owners
      for (int i = 0; i <= 4; i++) begin
         check("rr_grant", 32'(grant), 32'(1 << (i % 4)));
         if (i < 4) begin
            step();
            step();
            done = grant;
            step();
            done = '0;
            check("rr_gap", 32'(grant), 32'd0);
            step();
         end
      end

      // Pixel forwarding from owner 2 only
      done = 4'b0001;
      step();
      done = '0;
      check("rel_grant", 32'(grant), 32'd0);
      req = 4'b0101;
      step();
      check("pix_grant", 32'(grant), 32'b0100);
      plotIn = 4'b0101;
      xIn[18 +: 9] = 9'd319; yIn[16 +: 8] = 8'd239; colourIn[12 +: 6] = 6'h3F;
      xIn[0 +: 9]  = 9'd5;   yIn[0 +: 8]  = 8'd7;   colourIn[0 +: 6]  = 6'h11;
      step();
      check("pix_x", 32'(xOut), 32'd319);
      check("pix_y", 32'(yOut), 32'd239);
      check("pix_c", 32'(colourOut), 32'h3F);
      check("pix_p", 32'(plotOut), 32'd1);

      // Timeout: owner 1 never releases
      req = 4'b0010;
      plotIn = '0;
      step();
      step();
      check("tmo_grant", 32'(grant), 32'b0010);
      n_own = 1;
      for (int i = 0; i < 40 && grant != 4'b0; i++) begin
         step();
         if (grant != 4'b0) n_own++;
      end
      check("tmo_len",  32'(n_own), 32'd16);
      check("tmo_flag", 32'(timeoutFlag), 32'd1);
      req = '0;
      clearFlags = 1'b1;
      step();
      clearFlags = 1'b0;
      check("tmo_clear", 32'(timeoutFlag), 32'd0);

      // Overrun and set-over-clear precedence
      req = 4'b0001;
      step();
      check("ovr_grant", 32'(grant), 32'b0001);
      frameTick = 1'b1;
      step();
      check("ovr_set", 32'(frameOverrun), 32'd1);
      clearFlags = 1'b1;
      step();
      frameTick = 1'b0;
      check("ovr_prec", 32'(frameOverrun), 32'd1);
      step();
      clearFlags = 1'b0;
      check("ovr_clear", 32'(frameOverrun), 32'd0);

      // Reset mid-burst
      req = 4'b0010;
      step();
      step();
      check("mid_grant", 32'(grant), 32'b0010);
      plotIn = 4'b0010;
      step();
      check("mid_plot", 32'(plotOut), 32'd1);
      Resetn = 1'b0;
      step();
      check("mid_rst_grant", 32'(grant), 32'd0);
      check("mid_rst_plot",  32'(plotOut), 32'd0);
      check("mid_rst_busy",  32'(busy), 32'd0);
      Resetn = 1'b1;
      req = 4'b0011;
      step();
      check("mid_regrant", 32'(grant), 32'b0001);

      // Randomized traffic against the model
      for (int cyc = 0; cyc < 2000; cyc++) begin
         for (int b = 0; b < NREQ; b++) begin
            if ($urandom_range(7) == 0) req[b] = ~req[b];
            done[b] = ($urandom_range(15) == 0);
         end
         plotIn     = 4'($urandom);
         xIn        = 36'({$urandom, $urandom});
         yIn        = $urandom;
         colourIn   = 24'($urandom);
         frameTick  = ($urandom_range(19) == 0);
         clearFlags = ($urandom_range(24) == 0);
         Resetn     = ($urandom_range(199) != 0);
         step();
      end

      Resetn = 1'b1;
      step();
      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
